demux_1xn_stream: RTL and testbench

- Parametrised 1-to-N demultiplexer for data streams, with a valid/ready handshake on the input and on every output.
- Each output channel has a one-entry registered holding slot, so all outputs are registered and one channel stalling does not block the others.
- Two routing modes: directed, where the sel input picks the channel, and round-robin distribution.
- Sits between a single producer and N consumer lanes in the datapath.

---
 rtl/demux_1xn_stream_pkg.sv | 15 +
 rtl/demux_1xn_stream_if.sv | 23 ++
 rtl/demux_1xn_stream_slot.sv | 45 ++++
 rtl/demux_1xn_stream.sv | 75 +++++++
 tb/tb_demux_1xn_stream.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/demux_1xn_stream_pkg.sv
// Shared slot-state encoding and pointer helpers for the stream demux and
// for the arbiters built on the same round-robin scheme.
package demux_1xn_stream_pkg;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  // Explicit wrap at n-1 so non-power-of-2 channel counts cycle correctly.
  function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
    return (v == n - 1) ? 32'd0 : v + 32'd1;
  endfunction

endpackage

// File: rtl/demux_1xn_stream_if.sv
// Stream handshake bundle: one producer-side input, N flattened consumer lanes.
// Channel k of out_data occupies bits [k*W +: W].
interface demux_1xn_stream_if #(
  parameter int W = 4,
  parameter int N = 2
);
  logic [W-1:0]   in_data;
  logic           in_valid;
  logic           in_ready;
  logic [N*W-1:0] out_data;
  logic [N-1:0]   out_valid;
  logic [N-1:0]   out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/demux_1xn_stream_slot.sv
// One-entry registered holding slot: fill visible 1 cycle after the accepting edge.
// Drain and fill in the same cycle reload without a bubble; an empty slot presents zero.
module demux_slot
  import demux_1xn_stream_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_fill,
  input  logic [W-1:0] i_data,
  input  logic         i_out_ready,
  output logic         o_out_valid,
  output logic [W-1:0] o_out_data
);

  slot_state_t  r_state, w_state_nxt;
  logic [W-1:0] r_data, w_data_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= SLOT_EMPTY;
      r_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_data  <= w_data_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_data_nxt  = r_data;
    if (i_fill) begin
      w_state_nxt = SLOT_FULL;
      w_data_nxt  = i_data;
    end else if ((r_state == SLOT_FULL) && i_out_ready) begin
      w_state_nxt = SLOT_EMPTY;
      w_data_nxt  = '0;
    end
  end

  assign o_out_valid = (r_state == SLOT_FULL);
  assign o_out_data  = r_data;

endmodule

// File: rtl/demux_1xn_stream.sv
// 1-to-N stream demux, directed (sel) or round-robin; 1-cycle latency through per-channel slots.
// in_ready follows only the destination slot, so a stalled lane never blocks the others.
module demux_1xn_stream
  import demux_1xn_stream_pkg::*;
#(
  parameter int W = 4,
  parameter int N = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_mode,
  input  logic [$clog2(N)-1:0]  i_sel,
  demux_1xn_stream_if.slave     bus,
  output logic [$clog2(N)-1:0]  o_rr_ptr,
  output logic                  o_drop
);

  localparam int             SEL_W  = $clog2(N);
  localparam logic [SEL_W:0] NUM_CH = (SEL_W + 1)'(N);

  logic [SEL_W-1:0] r_rr_ptr;
  logic             r_drop;
  logic [SEL_W-1:0] w_dst;
  logic             w_dst_oor;
  logic             w_dst_busy;
  logic             w_xfer;
  logic [N-1:0]     w_fill;

  assign w_dst     = i_mode ? r_rr_ptr : i_sel;
  assign w_dst_oor = ({1'b0, w_dst} >= NUM_CH);

  // Busy only when the destination slot is full and not draining; an
  // out-of-range destination matches no slot and is therefore always sunk.
  always_comb begin
    w_dst_busy = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (w_dst == SEL_W'(k)) begin
        w_dst_busy = bus.out_valid[k] & ~bus.out_ready[k];
      end
    end
  end

  assign bus.in_ready = ~w_dst_busy;
  assign w_xfer       = bus.in_valid & ~w_dst_busy;

  for (genvar k = 0; k < N; k++) begin : g_slot
    assign w_fill[k] = w_xfer & (w_dst == SEL_W'(k));

    demux_slot #(.W(W)) u_slot (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_fill      (w_fill[k]),
      .i_data      (bus.in_data),
      .i_out_ready (bus.out_ready[k]),
      .o_out_valid (bus.out_valid[k]),
      .o_out_data  (bus.out_data[k*W +: W])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
      r_drop   <= 1'b0;
    end else begin
      r_drop <= w_xfer & w_dst_oor;
      if (w_xfer && i_mode) begin
        r_rr_ptr <= SEL_W'(wrap_inc(32'(r_rr_ptr), N));
      end
    end
  end

  assign o_rr_ptr = r_rr_ptr;
  assign o_drop   = r_drop;

endmodule

// File: tb/tb_demux_1xn_stream.sv
// Scoreboarded bench for demux_1xn_stream with three instances: N=2/W=4, N=4/W=8, N=3/W=8.
module tb_demux_1xn_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic       rst_n2, rst_n4, rst_n3;
  logic       mode2, mode4, mode3;
  logic [0:0] sel2, rr2;
  logic [1:0] sel4, rr4, sel3, rr3;
  logic       drop2, drop4, drop3;

  demux_1xn_stream_if #(.W(4), .N(2)) b2 ();
  demux_1xn_stream_if #(.W(8), .N(4)) b4 ();
  demux_1xn_stream_if #(.W(8), .N(3)) b3 ();

  demux_1xn_stream #(.W(4), .N(2)) u2 (
    .clk(clk), .rst_n(rst_n2), .i_mode(mode2), .i_sel(sel2),
    .bus(b2), .o_rr_ptr(rr2), .o_drop(drop2));
  demux_1xn_stream #(.W(8), .N(4)) u4 (
    .clk(clk), .rst_n(rst_n4), .i_mode(mode4), .i_sel(sel4),
    .bus(b4), .o_rr_ptr(rr4), .o_drop(drop4));
  demux_1xn_stream #(.W(8), .N(3)) u3 (
    .clk(clk), .rst_n(rst_n3), .i_mode(mode3), .i_sel(sel3),
    .bus(b3), .o_rr_ptr(rr3), .o_drop(drop3));

  logic [7:0] q2 [2][$];
  logic [7:0] q4 [4][$];
  logic [7:0] q3 [3][$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitors: each drain handshake pops the channel's scoreboard entry.
  always @(negedge clk) begin
    if (rst_n2 === 1'b1) begin
      for (int k = 0; k < 2; k++) begin
        if (b2.out_valid[k] && b2.out_ready[k]) begin
          if (q2[k].size() == 0) begin
            checks++; errors++;
            $display("FAIL n2 ch%0d unexpected word %0h", k, b2.out_data[k*4 +: 4]);
          end else chk($sformatf("n2 ch%0d data", k), 32'(b2.out_data[k*4 +: 4]), 32'(q2[k].pop_front()));
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n4 === 1'b1) begin
      for (int k = 0; k < 4; k++) begin
        if (b4.out_valid[k] && b4.out_ready[k]) begin
          if (q4[k].size() == 0) begin
            checks++; errors++;
            $display("FAIL n4 ch%0d unexpected word %0h", k, b4.out_data[k*8 +: 8]);
          end else chk($sformatf("n4 ch%0d data", k), 32'(b4.out_data[k*8 +: 8]), 32'(q4[k].pop_front()));
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n3 === 1'b1) begin
      for (int k = 0; k < 3; k++) begin
        if (b3.out_valid[k] && b3.out_ready[k]) begin
          if (q3[k].size() == 0) begin
            checks++; errors++;
            $display("FAIL n3 ch%0d unexpected word %0h", k, b3.out_data[k*8 +: 8]);
          end else chk($sformatf("n3 ch%0d data", k), 32'(b3.out_data[k*8 +: 8]), 32'(q3[k].pop_front()));
        end
      end
    end
  end

  // Drivers: present a word, wait (bounded) for in_ready, record expectation.
  task automatic send2(input logic m, input logic [0:0] s, input logic [3:0] d, input int exp_ch);
    int t = 0;
    mode2 = m; sel2 = s; b2.in_data = d; b2.in_valid = 1'b1;
    @(negedge clk);
    while (!b2.in_ready && t < 50) begin @(negedge clk); t++; end
    checks++;
    if (!b2.in_ready) begin errors++; $display("FAIL n2 send timeout: in_ready 0, expected 1"); end
    else if (exp_ch >= 0) q2[exp_ch].push_back({4'h0, d});
    @(posedge clk); #1;
    b2.in_valid = 1'b0;
  endtask

  task automatic send4(input logic m, input logic [1:0] s, input logic [7:0] d, input int exp_ch);
    int t = 0;
    mode4 = m; sel4 = s; b4.in_data = d; b4.in_valid = 1'b1;
    @(negedge clk);
    while (!b4.in_ready && t < 50) begin @(negedge clk); t++; end
    checks++;
    if (!b4.in_ready) begin errors++; $display("FAIL n4 send timeout: in_ready 0, expected 1"); end
    else if (exp_ch >= 0) q4[exp_ch].push_back(d);
    @(posedge clk); #1;
    b4.in_valid = 1'b0;
  endtask

  task automatic send3(input logic m, input logic [1:0] s, input logic [7:0] d, input int exp_ch);
    int t = 0;
    mode3 = m; sel3 = s; b3.in_data = d; b3.in_valid = 1'b1;
    @(negedge clk);
    while (!b3.in_ready && t < 50) begin @(negedge clk); t++; end
    checks++;
    if (!b3.in_ready) begin errors++; $display("FAIL n3 send timeout: in_ready 0, expected 1"); end
    else if (exp_ch >= 0) q3[exp_ch].push_back(d);
    @(posedge clk); #1;
    b3.in_valid = 1'b0;
  endtask

  initial begin
    rst_n2 = 1'b1; rst_n4 = 1'b1; rst_n3 = 1'b1;
    mode2 = 1'b0; mode4 = 1'b0; mode3 = 1'b0;
    sel2 = '0; sel4 = '0; sel3 = '0;
    b2.in_data = '0; b2.in_valid = 1'b0; b2.out_ready = 2'b11;
    b4.in_data = '0; b4.in_valid = 1'b0; b4.out_ready = 4'b1111;
    b3.in_data = '0; b3.in_valid = 1'b0; b3.out_ready = 3'b111;
    #2;
    rst_n2 = 1'b0; rst_n4 = 1'b0; rst_n3 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("n2 reset out_valid", 32'(b2.out_valid), 32'h0);
    chk("n2 reset out_data",  32'(b2.out_data),  32'h0);
    chk("n2 reset rr_ptr",    32'(rr2),          32'h0);
    chk("n2 reset drop",      32'(drop2),        32'h0);
    rst_n2 = 1'b1; rst_n4 = 1'b1; rst_n3 = 1'b1;

    // N=2 directed: first word after reset lands on ch1 only.
    send2(1'b0, 1'b1, 4'hA, 1);
    chk("n2 first out_valid", 32'(b2.out_valid), 32'h2);
    chk("n2 first out_data",  32'(b2.out_data),  32'hA0);
    @(posedge clk); #1;
    chk("n2 drained out_valid", 32'(b2.out_valid), 32'h0);
    chk("n2 drained out_data",  32'(b2.out_data),  32'h0);

    // N=2 backpressure on ch0 while ch1 keeps flowing.
    b2.out_ready = 2'b00;
    send2(1'b0, 1'b0, 4'h3, 0);
    sel2 = 1'b0; b2.in_data = 4'h5; b2.in_valid = 1'b1;
    @(negedge clk);
    chk("n2 stalled in_ready", 32'(b2.in_ready), 32'h0);
    chk("n2 stalled ch0 data", 32'(b2.out_data[3:0]), 32'h3);
    @(posedge clk); #1;
    send2(1'b0, 1'b1, 4'h7, 1);
    chk("n2 ch1 loads under stall", 32'(b2.out_valid), 32'h3);
    b2.out_ready = 2'b01;
    send2(1'b0, 1'b0, 4'h5, 0);
    chk("n2 no-bubble out_valid", 32'(b2.out_valid), 32'h3);
    chk("n2 no-bubble out_data",  32'(b2.out_data),  32'h75);
    b2.out_ready = 2'b11;
    repeat (2) @(posedge clk);
    #1;
    chk("n2 final out_valid", 32'(b2.out_valid), 32'h0);

    // N=4 round-robin wrap: 10..15 -> ch0,1,2,3,0,1.
    b4.out_ready = 4'b1111;
    send4(1'b1, 2'd0, 8'h10, 0);
    send4(1'b1, 2'd0, 8'h11, 1);
    send4(1'b1, 2'd0, 8'h12, 2);
    send4(1'b1, 2'd0, 8'h13, 3);
    send4(1'b1, 2'd0, 8'h14, 0);
    send4(1'b1, 2'd0, 8'h15, 1);
    chk("n4 rr_ptr after six", 32'(rr4), 32'h2);
    @(posedge clk); #1;
    chk("n4 rr drained", 32'(b4.out_valid), 32'h0);

    // N=4 reset mid-operation.
    b4.out_ready = 4'b0000;
    send4(1'b0, 2'd1, 8'h21, 1);
    send4(1'b0, 2'd3, 8'h23, 3);
    chk("n4 directed holds rr_ptr", 32'(rr4), 32'h2);
    send4(1'b1, 2'd0, 8'h22, 2);
    chk("n4 rr_ptr advanced", 32'(rr4), 32'h3);
    chk("n4 held out_valid", 32'(b4.out_valid), 32'hE);
    #2;
    rst_n4 = 1'b0;
    #1;
    chk("n4 async rst out_valid", 32'(b4.out_valid), 32'h0);
    chk("n4 async rst out_data",  32'(b4.out_data),  32'h0);
    chk("n4 async rst rr_ptr",    32'(rr4),          32'h0);
    for (int k = 0; k < 4; k++) q4[k].delete();
    @(posedge clk); #1;
    rst_n4 = 1'b1;
    b4.out_ready = 4'b1111;
    send4(1'b1, 2'd0, 8'h30, 0);
    chk("n4 post-reset out_valid", 32'(b4.out_valid), 32'h1);
    chk("n4 post-reset rr_ptr", 32'(rr4), 32'h1);

    // N=3: directed word, out-of-range drop, then non-power-of-2 wrap.
    send3(1'b0, 2'd2, 8'h42, 2);
    chk("n3 directed out_valid", 32'(b3.out_valid), 32'h4);
    @(posedge clk); #1;
    send3(1'b0, 2'd3, 8'hFF, -1);
    chk("n3 drop pulse",       32'(drop3),        32'h1);
    chk("n3 drop out_valid",   32'(b3.out_valid), 32'h0);
    chk("n3 drop rr_ptr",      32'(rr3),          32'h0);
    @(posedge clk); #1;
    chk("n3 drop cleared",     32'(drop3),        32'h0);
    send3(1'b1, 2'd0, 8'h50, 0);
    send3(1'b1, 2'd0, 8'h51, 1);
    send3(1'b1, 2'd0, 8'h52, 2);
    chk("n3 rr wrap to 0", 32'(rr3), 32'h0);
    send3(1'b1, 2'd0, 8'h53, 0);
    chk("n3 rr after wrap", 32'(rr3), 32'h1);
    chk("n3 no spurious drop", 32'(drop3), 32'h0);

    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) chk($sformatf("n2 ch%0d leftover", k), 32'(q2[k].size()), 32'h0);
    for (int k = 0; k < 4; k++) chk($sformatf("n4 ch%0d leftover", k), 32'(q4[k].size()), 32'h0);
    for (int k = 0; k < 3; k++) chk($sformatf("n3 ch%0d leftover", k), 32'(q3[k].size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
